// File: rtl/trace_pkg.sv
// Shared types and constants for the retire trace buffer: FSM encoding,
// flag bit positions and the packed record width.
package trace_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    POST    = 3'd2,
    FROZEN  = 3'd3,
    READOUT = 3'd4
  } trace_state_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  // Record layout is {pc, instr[31:0], result, flags[3:0]}.
  function automatic int rec_w(input int xlen);
    return 2 * xlen + 36;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: synchronous write, registered synchronous read.
// The read register holds its value while rd_en is low, which lets it act as a prefetch stage.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 100,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/retire_trace_buffer.sv
// Retire trace buffer: captures one record per retired instruction, freezes on
// PC trigger / full / stop, then drains the frozen contents over valid/ready.
module retire_trace_buffer
  import trace_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cap_valid,
  input  logic [XLEN-1:0] cap_pc,
  input  logic [31:0]     cap_instr,
  input  logic [XLEN-1:0] cap_result,
  input  logic [3:0]      cap_flags,
  input  logic            arm,
  input  logic            stop,
  input  logic            mode_wrap,
  input  logic            trig_en,
  input  logic [XLEN-1:0] trig_pc,
  input  logic [AW-1:0]   post_count,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [XLEN-1:0] rd_pc,
  output logic [31:0]     rd_instr,
  output logic [XLEN-1:0] rd_result,
  output logic [3:0]      rd_flags,
  output logic            rd_last,
  output logic [2:0]      state,
  output logic [AW:0]     count,
  output logic            triggered
);

  localparam int REC_W = rec_w(XLEN);
  localparam logic [AW:0]   FULL    = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  trace_state_t state_reg, state_next;
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, post_left_reg;
  logic [AW:0]      count_reg, reads_left_reg, load_left_reg;
  logic             triggered_reg, dout_valid_reg, rd_valid_reg, rd_last_reg;
  logic [REC_W-1:0] out_rec_reg, ram_rd_data;

  logic          capturing, wr_en, fill_stop, trig_hit, post_done;
  logic          load_out, xfer, issue, ram_rd_en;
  logic [AW:0]   count_inc, count_after;
  logic [AW-1:0] start_ptr, ram_rd_addr;

  assign capturing   = (state_reg == ARMED) || (state_reg == POST);
  assign wr_en       = cap_valid && capturing;
  assign count_inc   = (count_reg == FULL) ? FULL : count_reg + CNT_ONE;
  assign count_after = wr_en ? count_inc : count_reg;
  assign fill_stop   = wr_en && !mode_wrap && (count_inc == FULL);
  assign trig_hit    = wr_en && (state_reg == ARMED) && trig_en && (cap_pc == trig_pc);
  assign post_done   = wr_en && (state_reg == POST) && (post_left_reg == PTR_ONE);

  // A full buffer has wrapped (or just filled), so the oldest entry sits at wr_ptr.
  assign start_ptr = (count_reg == FULL) ? wr_ptr_reg : '0;

  // RAM output register is a one-deep prefetch behind the output register.
  assign xfer        = rd_valid_reg && rd_ready;
  assign load_out    = dout_valid_reg && (!rd_valid_reg || rd_ready);
  assign issue       = (state_reg == READOUT) && (reads_left_reg != '0) &&
                       (!dout_valid_reg || load_out);
  assign ram_rd_en   = (state_reg == FROZEN) || issue;
  assign ram_rd_addr = (state_reg == FROZEN) ? start_ptr : rd_ptr_reg;

  trace_ram #(.DEPTH(DEPTH), .W(REC_W)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_reg),
    .wr_data ({cap_pc, cap_instr, cap_result, cap_flags}),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (arm) state_next = ARMED;
      ARMED: begin
        if (fill_stop)     state_next = FROZEN;
        else if (trig_hit) state_next = (post_count == '0) ? FROZEN : POST;
        else if (stop)     state_next = (count_after == '0) ? IDLE : FROZEN;
      end
      POST:    if (fill_stop || post_done || stop) state_next = FROZEN;
      FROZEN:  state_next = READOUT;
      READOUT: if (xfer && rd_last_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      post_left_reg  <= '0;
      count_reg      <= '0;
      reads_left_reg <= '0;
      load_left_reg  <= '0;
      triggered_reg  <= 1'b0;
      dout_valid_reg <= 1'b0;
      rd_valid_reg   <= 1'b0;
      rd_last_reg    <= 1'b0;
      out_rec_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && arm) begin
        wr_ptr_reg    <= '0;
        count_reg     <= '0;
        triggered_reg <= 1'b0;
      end
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
        count_reg  <= count_inc;
      end
      if (trig_hit) begin
        triggered_reg <= 1'b1;
        post_left_reg <= post_count;
      end else if (wr_en && state_reg == POST) begin
        post_left_reg <= post_left_reg - PTR_ONE;
      end
      if (state_reg == FROZEN) begin
        rd_ptr_reg     <= start_ptr + PTR_ONE;
        reads_left_reg <= count_reg - CNT_ONE;
        load_left_reg  <= count_reg;
        dout_valid_reg <= 1'b1;
      end else if (state_reg == READOUT) begin
        if (issue) begin
          rd_ptr_reg     <= rd_ptr_reg + PTR_ONE;
          reads_left_reg <= reads_left_reg - CNT_ONE;
          dout_valid_reg <= 1'b1;
        end else if (load_out) begin
          dout_valid_reg <= 1'b0;
        end
        if (load_out) begin
          out_rec_reg   <= ram_rd_data;
          rd_valid_reg  <= 1'b1;
          rd_last_reg   <= (load_left_reg == CNT_ONE);
          load_left_reg <= load_left_reg - CNT_ONE;
        end else if (xfer) begin
          rd_valid_reg <= 1'b0;
          rd_last_reg  <= 1'b0;
        end
      end
    end
  end

  assign rd_valid  = rd_valid_reg;
  assign rd_last   = rd_last_reg;
  assign rd_pc     = out_rec_reg[REC_W-1 -: XLEN];
  assign rd_instr  = out_rec_reg[XLEN+35 -: 32];
  assign rd_result = out_rec_reg[XLEN+3 -: XLEN];
  assign rd_flags  = out_rec_reg[3:0];
  assign state     = state_reg;
  assign count     = count_reg;
  assign triggered = triggered_reg;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer: capture modes, trigger window,
// stop handling, stalled readout and asynchronous reset.
module tb_retire_trace_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cap_valid, arm, stop, mode_wrap, trig_en, rd_ready;
  logic [31:0] cap_pc, cap_instr, cap_result, trig_pc;
  logic [3:0]  cap_flags, post_count;
  logic        rd_valid, rd_last, triggered;
  logic [31:0] rd_pc, rd_instr, rd_result;
  logic [3:0]  rd_flags;
  logic [2:0]  state;
  logic [4:0]  count;

  int checks = 0;
  int failures = 0;
  logic [31:0] got_q[$];

  always #5 clk = ~clk;

  retire_trace_buffer #(.XLEN(32), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .cap_valid(cap_valid), .cap_pc(cap_pc),
    .cap_instr(cap_instr), .cap_result(cap_result), .cap_flags(cap_flags),
    .arm(arm), .stop(stop), .mode_wrap(mode_wrap), .trig_en(trig_en),
    .trig_pc(trig_pc), .post_count(post_count), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_instr(rd_instr),
    .rd_result(rd_result), .rd_flags(rd_flags), .rd_last(rd_last),
    .state(state), .count(count), .triggered(triggered)
  );

  function automatic logic [31:0] m_instr(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0013;
  endfunction

  function automatic logic [31:0] m_result(input logic [31:0] pc);
    return pc * 32'd3 + 32'd1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic retire(input logic [31:0] pc);
    cap_valid  = 1'b1;
    cap_pc     = pc;
    cap_instr  = m_instr(pc);
    cap_result = m_result(pc);
    cap_flags  = pc[5:2];
    @(negedge clk);
    cap_valid  = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  // Drain one dump into got_q; checks payload per record and hold-while-stalled.
  task automatic dump(input bit toggle);
    bit done = 1'b0;
    bit stalled = 1'b0;
    logic [63:0] held = '0;
    got_q.delete();
    for (int c = 0; c < 300 && !done; c++) begin
      rd_ready = toggle ? c[0] : 1'b1;
      if (stalled) begin
        chk("stall_hold", {rd_pc, rd_instr}, held);
        chk("stall_valid", {63'd0, rd_valid}, 64'd1);
      end
      stalled = 1'b0;
      if (rd_valid) begin
        if (rd_ready) begin
          got_q.push_back(rd_pc);
          chk($sformatf("payload_%0h", rd_pc), {rd_instr, rd_result},
              {m_instr(rd_pc), m_result(rd_pc)});
          chk($sformatf("flags_%0h", rd_pc), {60'd0, rd_flags}, {60'd0, rd_pc[5:2]});
          done = rd_last;
        end else begin
          stalled = 1'b1;
          held = {rd_pc, rd_instr};
        end
      end
      @(negedge clk);
    end
    rd_ready = 1'b0;
    chk("dump_done", {63'd0, done}, 64'd1);
    chk("dump_idle", {61'd0, state}, 64'd0);
    chk("dump_valid_low", {63'd0, rd_valid}, 64'd0);
  endtask

  task automatic chk_seq(input string tag, input logic [31:0] start, input int n);
    chk({tag, "_len"}, 64'(got_q.size()), 64'(n));
    for (int i = 0; i < got_q.size() && i < n; i++)
      chk($sformatf("%s_pc%0d", tag, i), {32'd0, got_q[i]}, {32'd0, start + 32'(4 * i)});
  endtask

  initial begin
    bit saw_valid;
    reset = 1'b0; cap_valid = 0; arm = 0; stop = 0; mode_wrap = 0; trig_en = 0;
    rd_ready = 0; cap_pc = 0; cap_instr = 0; cap_result = 0; cap_flags = 0;
    trig_pc = 0; post_count = 0;
    repeat (2) @(negedge clk);
    chk("rst_state", {61'd0, state}, 64'd0);
    chk("rst_outs", {rd_valid, rd_last, triggered, count, rd_pc},
        64'd0);
    reset = 1'b1;
    @(negedge clk);

    // T2: no-wrap fill of 16 entries
    pulse_arm();
    chk("t2_armed", {61'd0, state}, 64'd1);
    chk("t2_count0", {59'd0, count}, 64'd0);
    for (int i = 0; i < 16; i++) retire(32'(4 * i));
    chk("t2_frozen", {61'd0, state}, 64'd3);
    chk("t2_count", {59'd0, count}, 64'd16);
    @(negedge clk);
    chk("t2_readout", {61'd0, state}, 64'd4);
    chk("t2_no_valid_yet", {63'd0, rd_valid}, 64'd0);
    @(negedge clk);
    chk("t2_first_valid", {63'd0, rd_valid}, 64'd1);
    dump(1'b0);
    chk_seq("t2", 32'h0, 16);
    chk("t2_count_kept", {59'd0, count}, 64'd16);

    // T3: wrap with trigger at 0x40 and 3 post records
    mode_wrap = 1'b1; trig_en = 1'b1; trig_pc = 32'h40; post_count = 4'd3;
    pulse_arm();
    chk("t3_trig_clear", {63'd0, triggered}, 64'd0);
    for (int i = 0; i <= 32; i++) retire(32'(4 * i));
    chk("t3_triggered", {63'd0, triggered}, 64'd1);
    chk("t3_count", {59'd0, count}, 64'd16);
    dump(1'b0);
    chk_seq("t3", 32'h10, 16);

    // T4: trigger on 3rd retire with no post window
    mode_wrap = 1'b0; trig_pc = 32'h08; post_count = 4'd0;
    pulse_arm();
    for (int i = 0; i < 3; i++) retire(32'(4 * i));
    chk("t4_frozen", {61'd0, state}, 64'd3);
    dump(1'b0);
    chk_seq("t4", 32'h0, 3);
    trig_en = 1'b0;

    // T5: stalled readout with rd_ready toggling
    pulse_arm();
    for (int i = 0; i < 10; i++) retire(32'h100 + 32'(4 * i));
    pulse_stop();
    chk("t5_frozen", {61'd0, state}, 64'd3);
    dump(1'b1);
    chk_seq("t5", 32'h100, 10);

    // T6: stop coincident with 6th retire, then stop on empty buffer
    pulse_arm();
    for (int i = 0; i < 5; i++) retire(32'h200 + 32'(4 * i));
    stop = 1'b1;
    retire(32'h214);
    stop = 1'b0;
    chk("t6_frozen", {61'd0, state}, 64'd3);
    chk("t6_count", {59'd0, count}, 64'd6);
    dump(1'b0);
    chk_seq("t6", 32'h200, 6);
    pulse_arm();
    pulse_stop();
    chk("t6_empty_idle", {61'd0, state}, 64'd0);
    saw_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      retire(32'h300);
      saw_valid |= rd_valid;
    end
    chk("t6_no_valid", {63'd0, saw_valid}, 64'd0);
    chk("t6_idle_ignores_cap", {59'd0, count}, 64'd0);

    // T1: asynchronous reset in the middle of a dump
    pulse_arm();
    for (int i = 0; i < 4; i++) retire(32'h400 + 32'(4 * i));
    pulse_stop();
    saw_valid = 1'b0;
    for (int i = 0; i < 10 && !saw_valid; i++) begin
      @(negedge clk);
      saw_valid = rd_valid;
    end
    chk("t1_in_dump", {63'd0, saw_valid}, 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("t1_async_state", {61'd0, state}, 64'd0);
    chk("t1_async_outs", {rd_valid, rd_last, count}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t1_after_state", {61'd0, state}, 64'd0);
    chk("t1_after_rd", {rd_pc, 31'd0, rd_valid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
